// File: rtl/mem_acc_pkg.sv
// rtl/mem_acc_pkg.sv - shared types and helpers for the memory accessor port
package mem_acc_pkg;

  localparam int ACC_DW = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_e;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [31:0]       addr;
    logic [ACC_DW-1:0] wdata;
  } acc_req_t;

  // Size code 2'b11 falls through to the word case in both helpers.
  function automatic logic [ACC_DW-1:0] extend_load(input logic [1:0] size,
                                                   input logic is_unsigned,
                                                   input logic [ACC_DW-1:0] data);
    case (size)
      BYTE:    return {{(ACC_DW-8){data[7] & ~is_unsigned}}, data[7:0]};
      HALF:    return {{(ACC_DW-16){data[15] & ~is_unsigned}}, data[15:0]};
      default: return data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return addr[0];
      default: return addr != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_acc_fifo.sv
// rtl/mem_acc_fifo.sv - synchronous request buffer of acc_req_t entries
module mem_acc_fifo
  import mem_acc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  acc_req_t i_data,
  input  logic     i_pop,
  output acc_req_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  acc_req_t       r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mem_acc_port.sv
// rtl/mem_acc_port.sv - valid/ready load/store stream to controller accessor slot
module mem_acc_port
  import mem_acc_pkg::*;
#(
  parameter int BITSIZE    = ACC_DW,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_unsigned_i,
  input  logic [31:0]        req_addr_i,
  input  logic [BITSIZE-1:0] req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [BITSIZE-1:0] rsp_rdata_o,
  output logic               rsp_err_o,
  output logic [31:0]        acc_address_o,
  output logic               acc_read_o,
  output logic               acc_write_o,
  output logic [1:0]         acc_write_size_o,
  output logic [BITSIZE-1:0] acc_data_o,
  input  logic [BITSIZE-1:0] acc_data_i,
  input  logic               acc_done_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  acc_req_t           w_in_req;
  acc_req_t           w_head;
  acc_req_t           w_issue;
  logic               w_full;
  logic               w_empty;
  logic               w_in_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_bypass;
  logic               w_rsp_free;
  logic               w_acc_load;
  logic               w_acc_clear;
  logic               w_rsp_load;
  logic               w_rsp_err;
  logic [BITSIZE-1:0] w_rsp_data;
  state_e             r_state;
  state_e             w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_acc_read;
  logic               r_acc_write;
  logic [1:0]         r_acc_size;
  logic [31:0]        r_acc_addr;
  logic [BITSIZE-1:0] r_acc_data;
  logic               r_ld_unsigned;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [BITSIZE-1:0] r_rsp_rdata;

  assign w_in_req = '{write:       req_write_i,
                      size:        req_size_i,
                      is_unsigned: req_unsigned_i,
                      addr:        req_addr_i,
                      wdata:       req_wdata_i};

  assign req_ready_o = !w_full;
  assign w_in_fire   = req_valid_i && !w_full;
  assign w_rsp_free  = !r_rsp_valid || rsp_ready_i;
  assign w_push      = w_in_fire && !w_bypass;

  mem_acc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn_i),
    .i_push  (w_push),
    .i_data  (w_in_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // An aligned request arriving at an idle port with nothing queued skips the
  // buffer so the bus sees it the cycle after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_bypass    = 1'b0;
    w_issue     = w_head;
    w_acc_load  = 1'b0;
    w_acc_clear = 1'b0;
    w_rsp_load  = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_data  = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty && w_rsp_free) begin
          w_pop = 1'b1;
          if (is_misaligned(w_head.size, w_head.addr[1:0])) begin
            w_rsp_load = 1'b1;
            w_rsp_err  = 1'b1;
          end else begin
            w_acc_load  = 1'b1;
            w_state_nxt = BUSY;
          end
        end else if (w_empty && w_in_fire && w_rsp_free &&
                     !is_misaligned(w_in_req.size, w_in_req.addr[1:0])) begin
          w_bypass    = 1'b1;
          w_issue     = w_in_req;
          w_acc_load  = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (acc_done_i) begin
          w_rsp_load  = 1'b1;
          w_rsp_data  = r_acc_write ? '0 : extend_load(r_acc_size, r_ld_unsigned, acc_data_i);
          w_acc_clear = 1'b1;
          w_state_nxt = GAP;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_load  = 1'b1;
          w_rsp_err   = 1'b1;
          w_acc_clear = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      r_cnt         <= '0;
      r_acc_read    <= 1'b0;
      r_acc_write   <= 1'b0;
      r_acc_size    <= '0;
      r_acc_addr    <= '0;
      r_acc_data    <= '0;
      r_ld_unsigned <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      if (w_acc_load) begin
        r_acc_read    <= !w_issue.write;
        r_acc_write   <= w_issue.write;
        r_acc_size    <= w_issue.size;
        r_acc_addr    <= w_issue.addr;
        r_acc_data    <= w_issue.wdata;
        r_ld_unsigned <= w_issue.is_unsigned;
        r_cnt         <= '0;
      end else begin
        if (w_acc_clear) begin
          r_acc_read  <= 1'b0;
          r_acc_write <= 1'b0;
        end
        if (r_state == BUSY) r_cnt <= r_cnt + 1'b1;
      end
      if (w_rsp_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_rsp_err;
        r_rsp_rdata <= w_rsp_data;
      end else if (rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign acc_read_o       = r_acc_read;
  assign acc_write_o      = r_acc_write;
  assign acc_write_size_o = r_acc_size;
  assign acc_address_o    = r_acc_addr;
  assign acc_data_o       = r_acc_data;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_err_o        = r_rsp_err;
  assign rsp_rdata_o      = r_rsp_rdata;

endmodule

// File: tb/tb_mem_acc_port.sv
// tb/tb_mem_acc_port.sv - directed self-checking bench for mem_acc_port
module tb_mem_acc_port;

  logic        clk;
  logic        resetn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] acc_address_o;
  logic        acc_read_o;
  logic        acc_write_o;
  logic [1:0]  acc_write_size_o;
  logic [31:0] acc_data_o;
  logic [31:0] acc_data_i;
  logic        acc_done_i;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0]  EXT_SZ  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
  localparam logic        EXT_UN  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] EXT_IN  [5] = '{32'hABCD12F0, 32'hABCD12F0, 32'h12348001,
                                          32'h12348001, 32'h87654321};
  localparam logic [31:0] EXT_EXP [5] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001,
                                          32'h00008001, 32'h87654321};

  mem_acc_port #(
    .BITSIZE    (32),
    .FIFO_DEPTH (2),
    .TIMEOUT    (8)
  ) dut (
    .clk              (clk),
    .resetn_i         (resetn_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_write_i      (req_write_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_err_o        (rsp_err_o),
    .acc_address_o    (acc_address_o),
    .acc_read_o       (acc_read_o),
    .acc_write_o      (acc_write_o),
    .acc_write_size_o (acc_write_size_o),
    .acc_data_o       (acc_data_o),
    .acc_data_i       (acc_data_i),
    .acc_done_i       (acc_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for a single cycle; returns on the following falling edge.
  task automatic send_req(input logic w, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_write_i    = w;
    req_size_i     = sz;
    req_unsigned_i = un;
    req_addr_i     = a;
    req_wdata_i    = d;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    resetn_i = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0h want 1", req_ready_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0h want 0", rsp_valid_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %0h want 0", rsp_err_o); end
    total++; if ({acc_read_o, acc_write_o} !== 2'b00) begin bad++; $display("FAIL reset_acc_lines: got %0h want 0", {acc_read_o, acc_write_o}); end
    total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", rsp_rdata_o); end
    total++; if (acc_address_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %0h want 0", acc_address_o); end
    total++; if (acc_data_o !== 32'h0) begin bad++; $display("FAIL reset_acc_data: got %0h want 0", acc_data_o); end
    total++; if (acc_write_size_o !== 2'b00) begin bad++; $display("FAIL reset_size: got %0h want 0", acc_write_size_o); end
    resetn_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word;
    send_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++; if (acc_read_o !== 1'b1 || acc_write_o !== 1'b0) begin bad++; $display("FAIL lw_read_cycle%0d: got rd=%0h wr=%0h want rd=1 wr=0", i, acc_read_o, acc_write_o); end
      total++; if (acc_address_o !== 32'h40) begin bad++; $display("FAIL lw_addr_cycle%0d: got %0h want 40", i, acc_address_o); end
      if (i == 2) begin acc_done_i = 1'b1; acc_data_i = 32'h800000F0; end
      @(negedge clk);
    end
    acc_done_i = 1'b0;
    total++; if (acc_read_o !== 1'b0) begin bad++; $display("FAIL lw_gap_read: got %0h want 0", acc_read_o); end
    total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL lw_rsp_valid: got %0h want 1", rsp_valid_o); end
    total++; if (rsp_rdata_o !== 32'h800000F0) begin bad++; $display("FAIL lw_rdata: got %0h want 800000f0", rsp_rdata_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL lw_err: got %0h want 0", rsp_err_o); end
    @(negedge clk);
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL lw_rsp_drained: got %0h want 0", rsp_valid_o); end
  endtask

  task automatic test_extend;
    for (int i = 0; i < 5; i++) begin
      send_req(1'b0, EXT_SZ[i], EXT_UN[i], 32'h100, 32'h0);
      total++; if (acc_read_o !== 1'b1 || acc_write_size_o !== EXT_SZ[i]) begin bad++; $display("FAIL ext%0d_issue: got rd=%0h sz=%0h want rd=1 sz=%0h", i, acc_read_o, acc_write_size_o, EXT_SZ[i]); end
      acc_done_i = 1'b1;
      acc_data_i = EXT_IN[i];
      @(negedge clk);
      acc_done_i = 1'b0;
      total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== EXT_EXP[i]) begin bad++; $display("FAIL ext%0d_rdata: got v=%0h d=%0h want v=1 d=%0h", i, rsp_valid_o, rsp_rdata_o, EXT_EXP[i]); end
      total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL ext%0d_err: got %0h want 0", i, rsp_err_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_store_misaligned;
    send_req(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF);
    total++; if (acc_write_o !== 1'b1 || acc_read_o !== 1'b0) begin bad++; $display("FAIL st_lines: got wr=%0h rd=%0h want wr=1 rd=0", acc_write_o, acc_read_o); end
    total++; if (acc_write_size_o !== 2'b01 || acc_address_o !== 32'h42) begin bad++; $display("FAIL st_size_addr: got sz=%0h a=%0h want sz=1 a=42", acc_write_size_o, acc_address_o); end
    total++; if (acc_data_o !== 32'h0000BEEF) begin bad++; $display("FAIL st_data: got %0h want beef", acc_data_o); end
    acc_done_i = 1'b1;
    acc_data_i = 32'hFFFFFFFF;
    @(negedge clk);
    acc_done_i = 1'b0;
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL st_rsp: got v=%0h e=%0h d=%0h want v=1 e=0 d=0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    total++; if (acc_write_o !== 1'b0) begin bad++; $display("FAIL st_gap_write: got %0h want 0", acc_write_o); end
    @(negedge clk);
    send_req(1'b0, 2'd1, 1'b0, 32'h43, 32'h0);
    total++; if (rsp_valid_o !== 1'b0 || acc_read_o !== 1'b0) begin bad++; $display("FAIL mis_n1: got v=%0h rd=%0h want v=0 rd=0", rsp_valid_o, acc_read_o); end
    @(negedge clk);
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL mis_rsp: got v=%0h e=%0h d=%0h want v=1 e=1 d=0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    total++; if (acc_read_o !== 1'b0 || acc_write_o !== 1'b0) begin bad++; $display("FAIL mis_no_bus: got rd=%0h wr=%0h want 0 0", acc_read_o, acc_write_o); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    send_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h84;
    n = 0;
    if (acc_read_o === 1'b1 && acc_address_o === 32'h80) n++;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (acc_read_o === 1'b1 && acc_address_o === 32'h80) begin
        n++;
        @(negedge clk);
      end else break;
    end
    total++; if (n != 8) begin bad++; $display("FAIL to_read_cycles: got %0d want 8", n); end
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL to_rsp: got v=%0h e=%0h d=%0h want v=1 e=1 d=0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    @(negedge clk);
    total++; if (acc_read_o !== 1'b0) begin bad++; $display("FAIL to_idle_read: got %0h want 0", acc_read_o); end
    @(negedge clk);
    total++; if (acc_read_o !== 1'b1 || acc_address_o !== 32'h84) begin bad++; $display("FAIL to_next_issue: got rd=%0h a=%0h want rd=1 a=84", acc_read_o, acc_address_o); end
    acc_done_i = 1'b1;
    acc_data_i = 32'hCAFE0001;
    @(negedge clk);
    acc_done_i = 1'b0;
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'hCAFE0001) begin bad++; $display("FAIL to_next_rsp: got v=%0h e=%0h d=%0h want v=1 e=0 d=cafe0001", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_addr [2];
    logic [31:0] exp_data [2];
    exp_addr = '{32'h204, 32'h208};
    exp_data = '{32'h22222222, 32'h33333333};
    rsp_ready_i    = 1'b0;
    req_write_i    = 1'b0;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid_i = 1'b1;
      req_addr_i  = 32'h200 + 32'(4 * i);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_req%0d: got %0h want 1", i, req_ready_o); end
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full: got %0h want 0", req_ready_o); end
    total++; if (acc_read_o !== 1'b1 || acc_address_o !== 32'h200) begin bad++; $display("FAIL b2b_first: got rd=%0h a=%0h want rd=1 a=200", acc_read_o, acc_address_o); end
    acc_done_i = 1'b1;
    acc_data_i = 32'h11111111;
    @(negedge clk);
    acc_done_i = 1'b0;
    total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11111111) begin bad++; $display("FAIL b2b_rsp0: got v=%0h d=%0h want v=1 d=11111111", rsp_valid_o, rsp_rdata_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (acc_read_o !== 1'b0 || rsp_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_stall%0d: got rd=%0h v=%0h want rd=0 v=1", i, acc_read_o, rsp_valid_o); end
    end
    rsp_ready_i = 1'b1;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (acc_read_o === 1'b1) break;
      end
      total++; if (acc_read_o !== 1'b1 || acc_address_o !== exp_addr[j]) begin bad++; $display("FAIL b2b_issue%0d: got rd=%0h a=%0h want rd=1 a=%0h", j, acc_read_o, acc_address_o, exp_addr[j]); end
      acc_done_i = 1'b1;
      acc_data_i = exp_data[j];
      @(negedge clk);
      acc_done_i = 1'b0;
      total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_data[j]) begin bad++; $display("FAIL b2b_rsp%0d: got v=%0h d=%0h want v=1 d=%0h", j + 1, rsp_valid_o, rsp_rdata_o, exp_data[j]); end
    end
  endtask

  task automatic test_reset_mid;
    send_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    total++; if (acc_read_o !== 1'b1) begin bad++; $display("FAIL rst_busy: got %0h want 1", acc_read_o); end
    req_valid_i = 1'b1;
    req_addr_i  = 32'h304;
    @(negedge clk);
    req_valid_i = 1'b0;
    #2 resetn_i = 1'b0;
    #1;
    total++; if (acc_read_o !== 1'b0) begin bad++; $display("FAIL rst_read_drop: got %0h want 0", acc_read_o); end
    total++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_rsp_ready: got v=%0h rdy=%0h want v=0 rdy=1", rsp_valid_o, req_ready_o); end
    @(negedge clk);
    resetn_i = 1'b1;
    @(negedge clk);
    acc_done_i = 1'b1;
    acc_data_i = 32'h5A5A5A5A;
    @(negedge clk);
    acc_done_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_valid_o !== 1'b0 || acc_read_o !== 1'b0) begin bad++; $display("FAIL rst_quiet%0d: got v=%0h rd=%0h want 0 0", i, rsp_valid_o, acc_read_o); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn_i       = 1'b0;
    req_valid_i    = 1'b0;
    req_write_i    = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0;
    req_wdata_i    = 32'h0;
    rsp_ready_i    = 1'b1;
    acc_data_i     = 32'h0;
    acc_done_i     = 1'b0;
    test_reset();
    test_load_word();
    test_extend();
    test_store_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
